m_deser: RTL and testbench

Serial-to-parallel deframer that sits directly downstream of the 4-stage serial shift/delay stage and consumes its one-bit-per-clock output stream. It detects a start bit, collects DATA_W data bits LSB-first, and checks the stop bit. It delivers each good word through a single-entry valid/ready holding register. Framing and overrun events are reported as one-cycle pulses.

---
 rtl/m_deser_pkg.sv | 16 +
 rtl/m_deser_hold.sv | 55 +++++
 rtl/m_deser.sv | 134 +++++++++++++
 tb/tb_m_deser.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/m_deser_pkg.sv
// Shared types and line-level constants for the m_deser serial deframer.
// M_DESER_PARITY_EN (optional) enables the even-parity state in m_deser.
package m_deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/m_deser_hold.sv
// Single-entry valid/ready holding register for m_deser.
// A load coinciding with a consume replaces the word; a load into a full, unconsumed slot raises overrun.
module m_deser_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              consume;

  assign consume = valid_q && ready_i;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i) begin
      if (!valid_q || consume) begin
        data_d  = load_data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/m_deser.sv
// Serial-to-parallel deframer: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
// Optional parity checking and the w_par_err port are compiled in with M_DESER_PARITY_EN.
module m_deser
  import m_deser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_in,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_busy,
  output logic              w_frame_err,
  output logic              w_overrun
`ifdef M_DESER_PARITY_EN
  ,
  output logic              w_par_err
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ferr_q, ferr_d;
  logic              word_good;
`ifdef M_DESER_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    word_good = 1'b0;
`ifdef M_DESER_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (w_in == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
`ifdef M_DESER_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      DATA: begin
        shift_d[cnt_q] = w_in;
        cnt_d          = cnt_q + CNT_W'(1);
`ifdef M_DESER_PARITY_EN
        par_d          = par_q ^ w_in;
`endif
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
`ifdef M_DESER_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef M_DESER_PARITY_EN
      PARITY: begin
        par_d   = par_q ^ w_in;
        state_d = STOP;
      end
`endif
      STOP: begin
        // A bad stop bit is consumed here; it never doubles as the next start bit.
        state_d = IDLE;
        if (w_in == STOP_BIT) begin
`ifdef M_DESER_PARITY_EN
          word_good = !par_q;
          perr_d    = par_q;
`else
          word_good = 1'b1;
`endif
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
`ifdef M_DESER_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
`ifdef M_DESER_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  m_deser_hold #(.DATA_W(DATA_W)) u_hold (
    .clk_i       (w_clk),
    .srst_i      (w_rst),
    .load_i      (word_good),
    .load_data_i (shift_q),
    .ready_i     (w_ready),
    .data_o      (w_data),
    .valid_o     (w_valid),
    .overrun_o   (w_overrun)
  );

  assign w_busy      = (state_q != IDLE);
  assign w_frame_err = ferr_q;
`ifdef M_DESER_PARITY_EN
  assign w_par_err   = perr_q;
`endif

endmodule

// File: tb/tb_m_deser.sv
// Scoreboard bench for m_deser (DATA_W=8): expected words queued at stimulus, popped on each handshake.
// Parity cases run only when M_DESER_PARITY_EN is defined.
module tb_m_deser;

  logic       w_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic       w_in = 1'b0;
  logic [7:0] w_data;
  logic       w_valid;
  logic       w_ready = 1'b1;
  logic       w_busy;
  logic       w_frame_err;
  logic       w_overrun;
`ifdef M_DESER_PARITY_EN
  logic       w_par_err;
  int         obs_perr = 0;
  int         exp_perr = 0;
`endif

  m_deser #(.DATA_W(8)) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .w_in        (w_in),
    .w_data      (w_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_busy      (w_busy),
    .w_frame_err (w_frame_err),
    .w_overrun   (w_overrun)
`ifdef M_DESER_PARITY_EN
    ,
    .w_par_err   (w_par_err)
`endif
  );

  always #5 w_clk = ~w_clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb_q[$];
  int         obs_ferr = 0;
  int         obs_ovr = 0;
  int         exp_ferr = 0;
  int         exp_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: a handshake happens at the next rising edge whenever valid&&ready here.
  always @(negedge w_clk) begin
    if (w_frame_err === 1'b1) obs_ferr++;
    if (w_overrun === 1'b1) obs_ovr++;
`ifdef M_DESER_PARITY_EN
    if (w_par_err === 1'b1) obs_perr++;
`endif
    if (w_valid === 1'b1 && w_ready === 1'b1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL word: got %0h expected none", w_data);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        if (w_data !== e) begin
          bad++;
          $display("FAIL word: got %0h expected %0h", w_data, e);
        end else begin
          $display("ok   word: %0h", w_data);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    w_in = b;
    @(posedge w_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask

  // Sends start, d LSB-first, [parity], stop; rdy_stop raises w_ready only for the stop edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                            input logic rdy_stop);
    drive_bit(1'b1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef M_DESER_PARITY_EN
    drive_bit(par_b);
`else
    if (par_b) begin end
`endif
    if (rdy_stop) w_ready = 1'b1;
    drive_bit(stop_b);
    if (rdy_stop) w_ready = 1'b0;
  endtask

  task automatic chk_events(input string name);
    chk({name, "_ferr"}, obs_ferr, exp_ferr);
    chk({name, "_ovr"}, obs_ovr, exp_ovr);
`ifdef M_DESER_PARITY_EN
    chk({name, "_perr"}, obs_perr, exp_perr);
`endif
  endtask

  initial begin
    // Reset state
    idle(2);
    chk("rst_valid", w_valid, 0);
    chk("rst_data", w_data, 0);
    chk("rst_busy", w_busy, 0);
    chk("rst_ferr", w_frame_err, 0);
    chk("rst_ovr", w_overrun, 0);
    w_rst = 1'b0;
    idle(2);

    // Single frame 0xA5, ready high: valid for exactly one cycle after the stop edge
    w_ready = 1'b1;
    sb_q.push_back(8'hA5);
    drive_bit(1'b1);
    chk("a5_busy", w_busy, 1);
    for (int i = 0; i < 8; i++) drive_bit(((8'hA5 >> i) & 8'h01) != 0);
`ifdef M_DESER_PARITY_EN
    drive_bit(1'b0);
`endif
    chk("a5_valid_pre", w_valid, 0);
    drive_bit(1'b0);
    chk("a5_valid", w_valid, 1);
    chk("a5_data", w_data, 8'hA5);
    drive_bit(1'b0);
    chk("a5_valid_drop", w_valid, 0);
    idle(2);
    chk_events("a5");

    // Back-to-back 0x3C, 0xFF with ready low: overrun on second stop edge
    w_ready = 1'b0;
    sb_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    exp_ovr++;
    chk("ovr_pulse", w_overrun, 1);
    chk("ovr_data", w_data, 8'h3C);
    chk("ovr_valid", w_valid, 1);
    idle(1);
    chk("ovr_pulse_end", w_overrun, 0);
    idle(2);
    chk("ovr_data_held", w_data, 8'h3C);
    w_ready = 1'b1;
    idle(1);
    chk("ovr_consumed", w_valid, 0);
    idle(1);
    chk_events("ovr");

    // Same frames, ready only on the second stop edge: consume and load coincide
    w_ready = 1'b0;
    sb_q.push_back(8'h3C);
    sb_q.push_back(8'hFF);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    chk("swap_valid", w_valid, 1);
    chk("swap_data", w_data, 8'hFF);
    chk("swap_ovr", w_overrun, 0);
    idle(2);
    w_ready = 1'b1;
    idle(2);
    chk("swap_drained", w_valid, 0);
    chk_events("swap");

    // Frame error on 0x00, then good 0x81
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    exp_ferr++;
    chk("ferr_pulse", w_frame_err, 1);
    chk("ferr_valid", w_valid, 0);
    chk("ferr_idle", w_busy, 0);
    idle(1);
    chk("ferr_pulse_end", w_frame_err, 0);
    sb_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    chk("f81_data", w_data, 8'h81);
    idle(2);
    chk_events("ferr");

    // Reset during 4th data bit of 0x55, then 0x12
    drive_bit(1'b1);
    for (int i = 0; i < 3; i++) drive_bit(((8'h55 >> i) & 8'h01) != 0);
    w_rst = 1'b1;
    drive_bit(1'b0);
    w_rst = 1'b0;
    chk("rst_mid_busy", w_busy, 0);
    chk("rst_mid_valid", w_valid, 0);
    idle(2);
    sb_q.push_back(8'h12);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    chk("f12_data", w_data, 8'h12);
    idle(2);
    chk_events("rst_mid");

`ifdef M_DESER_PARITY_EN
    sb_q.push_back(8'h07);
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    chk("par_ok_data", w_data, 8'h07);
    chk("par_ok_perr", w_par_err, 0);
    idle(2);
    send_frame(8'h07, 1'b0, 1'b0, 1'b0);
    exp_perr++;
    chk("par_bad_perr", w_par_err, 1);
    chk("par_bad_valid", w_valid, 0);
    idle(2);
    chk_events("par");
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
